// File: rtl/mem_split_unit_pkg.sv
// Shared encodings for the memory-stage access formatter: request sizes,
// split FSM states and the byte-lane mask helper.
package mem_split_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    // Right-aligned lane mask for an access size; size 3 behaves as a word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001;
            SZ_HALF: m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_split_unit_load_merge.sv
// Reassembles a right-aligned load value from the two word reads of a split
// load: low part from the first word, high part from the second.
module load_merge (
    input  logic [31:0] l_word,
    input  logic [31:0] rd_word,
    input  logic [1:0]  k,
    output logic [31:0] merged
);

    logic [5:0] sh_lo;
    logic [5:0] sh_hi;

    assign sh_lo  = {1'b0, k, 3'b000};
    assign sh_hi  = 6'd32 - sh_lo;
    assign merged = (l_word >> sh_lo) | (rd_word << sh_hi);

endmodule

// File: rtl/mem_split_unit.sv
// BRAM port-A access formatter for the MEM stage. With MISALIGN_SPLIT_EN
// defined, misaligned accesses become two word accesses; otherwise they trap.
module mem_split_unit
    import mem_split_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] mem_rd,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [3:0]  mem_we,
    output logic        stall_req,
    output logic        split_ld_w,
    output logic [31:0] ld_data_w
`ifdef MISALIGN_SPLIT_EN
`else
    ,
    output logic        misalign_exc
`endif
);

    logic [1:0]  k;
    logic [31:0] base;
    logic [3:0]  mask;
    logic        misaligned;
    logic [4:0]  sh_lo;
    logic [3:0]  lanes_lo;
    logic [31:0] wd_lo;

    logic [31:0] mem_a_c;
    logic [31:0] mem_wd_c;
    logic [3:0]  mem_we_c;
    logic        stall_c;
    logic        split_c;

    logic [31:0] l_word;
    logic [1:0]  k_w;
    logic [31:0] merged;

    assign k          = req_addr[1:0];
    assign base       = {req_addr[31:2], 2'b00};
    assign mask       = lane_mask(req_size);
    assign misaligned = ((req_size == SZ_HALF) && (k == 2'd3)) ||
                        ((req_size >= SZ_WORD) && (k != 2'd0));
    assign sh_lo      = {k, 3'b000};
    assign lanes_lo   = mask << k;
    assign wd_lo      = req_wdata << sh_lo;

`ifdef MISALIGN_SPLIT_EN
    // stall_req is the only flow control: while it is high the upstream
    // registers hold, so req_* stay stable into the SECOND cycle; en low
    // means someone else holds the pipe and the current access is re-driven.
    logic [31:0] hi;
    logic [5:0]  sh_hi;
    logic [3:0]  lanes_hi;
    logic [31:0] wd_hi;
    state_t      state;
    state_t      state_nxt;
    logic        ld_split;
    logic        split_q;

    assign hi       = base + 32'd4;
    assign sh_hi    = 6'd32 - {1'b0, sh_lo};
    assign lanes_hi = mask >> (3'd4 - {1'b0, k});
    assign wd_hi    = req_wdata >> sh_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_word   <= '0;
            ld_split <= 1'b0;
            split_q  <= 1'b0;
            k_w      <= '0;
        end else begin
            // mem_rd holds the low word only in the first SECOND cycle.
            if ((state == ST_SECOND) && !ld_split) begin
                l_word   <= mem_rd;
                ld_split <= req_valid && !req_store;
            end
            if (en) begin
                split_q <= (state == ST_SECOND) && req_valid && !req_store;
                if (state == ST_SECOND) begin
                    k_w      <= k;
                    ld_split <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mem_a_c   = base;
        mem_wd_c  = wd_lo;
        mem_we_c  = '0;
        stall_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_store) begin
                        mem_we_c = lanes_lo;
                    end
                    if (misaligned) begin
                        stall_c = 1'b1;
                        if (en) begin
                            state_nxt = ST_SECOND;
                        end
                    end
                end
            end
            ST_SECOND: begin
                mem_a_c  = hi;
                mem_wd_c = wd_hi;
                if (req_valid && req_store) begin
                    mem_we_c = lanes_hi;
                end
                if (en) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign split_c = split_q;
`else
    logic exc_q;
    logic exc_done;
    logic mis_now;

    assign mis_now = req_valid && misaligned;

    // exc_done suppresses repeat pulses while a trapping access is held by en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_q    <= 1'b0;
            exc_done <= 1'b0;
        end else begin
            exc_q    <= mis_now && !exc_done;
            exc_done <= mis_now && !en;
        end
    end

    always_comb begin
        mem_a_c  = base;
        mem_wd_c = wd_lo;
        mem_we_c = '0;
        stall_c  = 1'b0;
        if (req_valid && req_store && !misaligned) begin
            mem_we_c = lanes_lo;
        end
    end

    assign split_c      = 1'b0;
    assign l_word       = '0;
    assign k_w          = '0;
    assign misalign_exc = rst_n & exc_q;
`endif

    load_merge u_load_merge (
        .l_word  (l_word),
        .rd_word (mem_rd),
        .k       (k_w),
        .merged  (merged)
    );

    assign mem_a      = rst_n ? mem_a_c  : 32'd0;
    assign mem_wd     = rst_n ? mem_wd_c : 32'd0;
    assign mem_we     = rst_n ? mem_we_c : 4'd0;
    assign stall_req  = rst_n & stall_c;
    assign split_ld_w = rst_n & split_c;
    assign ld_data_w  = rst_n ? merged : 32'd0;

endmodule
